// File: rtl/encrypt_pkg.sv
// Shared definitions for the encrypt toy block cipher.
//   DATA_W : datapath width (8)
//   STAGES : pipeline depth (3)
//   SBOX   : 4-bit substitution table, indexed by nibble value
//   rotl8  : circular left rotate of a byte by 0..7 positions
package encrypt_pkg;

  localparam int DATA_W = 8;
  localparam int STAGES = 3;

  localparam logic [3:0] SBOX [0:15] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  // Rotating a doubled copy left and keeping the upper byte gives the
  // circular rotate; an amount of 0 returns the input unchanged.
  function automatic logic [DATA_W-1:0] rotl8(input logic [DATA_W-1:0] data,
                                              input logic [2:0]        amt);
    logic [2*DATA_W-1:0] dbl;
    dbl = {data, data} << amt;
    return dbl[2*DATA_W-1:DATA_W];
  endfunction

endpackage

// File: rtl/encrypt_sbox4.sv
// Combinational 4-bit to 4-bit S-box lookup.
//   nib_in  : input nibble
//   nib_out : substituted nibble
module encrypt_sbox4
  import encrypt_pkg::*;
(
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  assign nib_out = SBOX[nib_in];

endmodule

// File: rtl/encrypt.sv
// Pipelined 8-bit toy block cipher / data scrambler.
// Three register stages: key whitening, nibble S-box substitution, then a
// key-dependent rotate with nibble-swapped key post-whitening. The key is
// carried alongside its data so key changes never affect data in flight.
//   clock     : rising-edge clock
//   reset     : asynchronous active-high clear of every pipeline register
//   number    : plaintext, sampled every rising edge
//   key       : key, sampled with number
//   encnumber : ciphertext, registered, valid 3 edges after its input
module encrypt
  import encrypt_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] number,
  input  logic [DATA_W-1:0] key,
  output logic [DATA_W-1:0] encnumber
);

  logic [DATA_W-1:0] s_p1_q, s_p1_d;
  logic [DATA_W-1:0] k_p1_q, k_p1_d;
  logic [DATA_W-1:0] s_p2_q, s_p2_d;
  logic [DATA_W-1:0] k_p2_q, k_p2_d;
  logic [DATA_W-1:0] enc_p3_q, enc_p3_d;
  logic [3:0]        sbox_hi, sbox_lo;

  encrypt_sbox4 u_sbox_hi (
    .nib_in  (s_p1_q[7:4]),
    .nib_out (sbox_hi)
  );

  encrypt_sbox4 u_sbox_lo (
    .nib_in  (s_p1_q[3:0]),
    .nib_out (sbox_lo)
  );

  always_comb begin
    // stage 1: key whitening
    s_p1_d   = number ^ key;
    k_p1_d   = key;
    // stage 2: nibble substitution
    s_p2_d   = {sbox_hi, sbox_lo};
    k_p2_d   = k_p1_q;
    // stage 3: key-dependent rotate and post-whitening
    enc_p3_d = rotl8(s_p2_q, k_p2_q[2:0]) ^ {k_p2_q[3:0], k_p2_q[7:4]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_p1_q   <= '0;
      k_p1_q   <= '0;
      s_p2_q   <= '0;
      k_p2_q   <= '0;
      enc_p3_q <= '0;
    end else begin
      s_p1_q   <= s_p1_d;
      k_p1_q   <= k_p1_d;
      s_p2_q   <= s_p2_d;
      k_p2_q   <= k_p2_d;
      enc_p3_q <= enc_p3_d;
    end
  end

  assign encnumber = enc_p3_q;

endmodule

// File: tb/tb_encrypt.sv
// Scoreboard testbench for encrypt. Stimulus pushes expected ciphertext
// with the cycle it is due; a monitor pops and compares after each edge.
module tb_encrypt;

  logic       clock;
  logic       reset;
  logic [7:0] number;
  logic [7:0] key;
  logic [7:0] encnumber;

  encrypt dut (
    .clock     (clock),
    .reset     (reset),
    .number    (number),
    .key       (key),
    .encnumber (encnumber)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] exp;
    int         due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  int sbox_tbl [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  // Reference cipher written with plain integer arithmetic.
  function automatic logic [7:0] model(input logic [7:0] n, input logic [7:0] k);
    int x, s, r, rot, sw;
    x   = int'(n ^ k);
    s   = sbox_tbl[x / 16] * 16 + sbox_tbl[x % 16];
    r   = int'(k) % 8;
    rot = ((s << r) | (s >> (8 - r))) & 255;
    sw  = (int'(k) % 16) * 16 + int'(k) / 16;
    return 8'(rot ^ sw);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one input pair (caller is at a negedge) and queue its result.
  task automatic apply(input logic [7:0] n, input logic [7:0] k, input logic [7:0] exp);
    exp_t e;
    number = n;
    key    = k;
    e.exp  = exp;
    e.due  = cyc + 3;
    sb_q.push_back(e);
  endtask

  // Reset release at a negedge: the first edge moves the cleared stage-2
  // value (00) to the output, the second moves SBOX(00)=CC with key 00.
  task automatic release_reset();
    exp_t e;
    reset = 1'b0;
    e.exp = 8'h00; e.due = cyc + 1; sb_q.push_back(e);
    e.exp = 8'hCC; e.due = cyc + 2; sb_q.push_back(e);
  endtask

  // Monitor
  always @(posedge clock) begin
    exp_t e;
    cyc++;
    #1;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      if (e.due < cyc) begin
        n_check++;
        n_fail++;
        $display("FAIL sb_missed: got %h expected %h (due %0d)", encnumber, e.exp, e.due);
      end else begin
        check("sb_out", encnumber, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] n_const;
    logic [7:0] r_n, r_k;
    reset  = 1'b1;
    number = 8'($urandom);
    key    = 8'($urandom);

    // Held reset with clock toggling
    repeat (2) begin
      @(posedge clock); #1;
      check("reset_hold", encnumber, 8'h00);
      number = 8'($urandom);
      key    = 8'($urandom);
    end

    // Known vector held for three edges
    @(negedge clock);
    release_reset();
    apply(8'h46, 8'h93, 8'hBA);
    repeat (2) begin
      @(negedge clock);
      apply(8'h46, 8'h93, 8'hBA);
    end

    // Back-to-back known vectors and the all-zero case
    @(negedge clock); apply(8'hC9, 8'hAC, 8'hC0);
    @(negedge clock); apply(8'hA5, 8'h5A, 8'h2D);
    @(negedge clock); apply(8'hF0, 8'hB1, 8'h30);
    @(negedge clock); apply(8'h00, 8'h00, 8'hCC);

    // Constant plaintext, key changing every cycle (all rotate amounts)
    n_const = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      r_k = 8'($urandom);
      r_k[2:0] = 3'(i);
      @(negedge clock); apply(n_const, r_k, model(n_const, r_k));
    end

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      r_n = 8'($urandom);
      r_k = 8'($urandom);
      @(negedge clock); apply(r_n, r_k, model(r_n, r_k));
    end

    // Reset asserted between edges while the pipeline is full
    @(posedge clock); #3;
    reset = 1'b1;
    sb_q.delete();
    #1;
    check("reset_async", encnumber, 8'h00);
    @(posedge clock); #1;
    check("reset_midstream_hold", encnumber, 8'h00);

    @(negedge clock);
    release_reset();
    apply(8'h46, 8'h93, 8'hBA);
    for (int i = 0; i < 8; i++) begin
      r_n = 8'($urandom);
      r_k = 8'($urandom);
      @(negedge clock); apply(r_n, r_k, model(r_n, r_k));
    end

    // Drain with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clock);
    n_check++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
